flicker_slew: RTL and testbench
===============================

Name: flicker_slew

Overview:
- Sits between the flicker generator and the PWM stage. It consumes the raw 8-bit brightness targets from the flicker generator and drives the PWM duty value.
- Ramps a working level toward the latest target in bounded steps, one step per enable tick, so the flame changes smoothly instead of jumping.
- Clamps the level to a floor, so the candle never goes fully dark.
- Hands the level to the PWM only at PWM period boundaries, so the duty cycle never changes mid-period.

Parameters:
WIDTH, 8, brightness width in bits
STEP, 4, maximum change of the working level per enable tick; must be at least 1 and at most 2^WIDTH-1
MIN_LEVEL, 16, floor applied to every accepted target
RESET_LEVEL, 128, level after reset; must be at least MIN_LEVEL

Ports:
clk  in  1  system clock (the only clock)
reset  in  1  synchronous, active-high reset
enable  in  1  ramp tick strobe, one cycle wide (from a divider counter)
target  in  WIDTH  new brightness target from the flicker generator
target_valid  in  1  target is valid this cycle
period_start  in  1  PWM period boundary strobe, one cycle wide
value  out  WIDTH  duty value to the PWM; changes only on period_start
settled  out  1  working level equals target and value is up to date
ramp_dir  out  2  current state: 00 HOLD, 01 RAMP_UP, 10 RAMP_DOWN

Behaviour:
- Reset (synchronous, active-high): tgt_q, cur_q and value are set to RESET_LEVEL; state is HOLD; settled is 1. Reset overrides every other input in the same cycle.
- Target acceptance:
  - When target_valid=1, tgt_q is loaded with max(target, MIN_LEVEL) on the next edge.
  - No handshake; target_valid is accepted every cycle, and the last write wins.
- Ramp, on each cycle with enable=1:
  - The step uses the tgt_q and cur_q values held before that edge. A target written in the same cycle takes effect from the next tick.
  - If cur_q < tgt_q: cur_q is increased by min(STEP, tgt_q-cur_q).
  - If cur_q > tgt_q: cur_q is decreased by min(STEP, cur_q-tgt_q).
  - If cur_q equals tgt_q: cur_q is unchanged.
  - Difference arithmetic uses WIDTH+1 bits. The level never overshoots the target and never wraps past 0 or 2^WIDTH-1.
- Output register:
  - On period_start=1, value is loaded with the pre-edge cur_q.
  - If period_start and enable fall in the same cycle, value takes the old cur_q and the stepped level appears at the next period_start.
- State, registered, recomputed every cycle from the next-state cur_q and tgt_q:
  - HOLD when they are equal, RAMP_UP when cur_q < tgt_q, RAMP_DOWN when cur_q > tgt_q.
  - A direction reversal mid-ramp goes straight from RAMP_UP to RAMP_DOWN (or the reverse) with no HOLD in between.
- settled is a registered output: 1 when the next state is HOLD and the next value equals the next cur_q.
- Without enable ticks the level freezes; without period_start strobes value freezes. Both are legal.
- Reset mid-ramp returns to the reset state on the next edge, discarding the pending target.

Decomposition:
- Shared package candle_pkg:
  - ramp_dir encoding constants (HOLD, RAMP_UP, RAMP_DOWN)
  - default brightness width constant, shared with the flicker and PWM stages
- One natural sub-module, slew_step: purely combinational.
  - Inputs: cur and tgt.
  - Outputs: next level and direction, with the STEP clamp and the no-overshoot rule.
  - Can be verified exhaustively at WIDTH=8.

Test Plan:
1. Reset held 2 cycles, then released -> value=128, settled=1, ramp_dir=00; no change with idle inputs for 100 cycles.
2. target=140 valid, then 3 enable ticks, period_start after each tick -> cur 132, 136, 140; value follows one period_start later; ramp_dir 01 then 00; settled=1 after the last period_start.
3. target=5 valid -> tgt_q=16; after 28 enable ticks, cur=16 and ramp_dir=00; further ticks hold at 16.
4. target=130 from level 128 -> one tick gives 130, no overshoot. With the level set to 252, target=255 -> 255, no wrap; same check for 3 -> floor at 16.
5. target_valid (target=200) and enable in the same cycle at level 128 -> level stays 128 that tick and reaches 132 on the next tick. Separately, enable and period_start in the same cycle -> value takes the pre-step level.
6. Reset asserted mid-ramp (level 180, target 240) -> next cycle value=128, tgt_q=128, ramp_dir=00, settled=1.

Source files
------------

// File: rtl/candle_pkg.sv
// candle_pkg
//   Shared definitions for the candle pipeline (flicker generator, slew
//   limiter, PWM stage).
//   - BRIGHT_WIDTH : default brightness width used by every stage
//   - ramp_dir_e   : direction encoding reported by the slew limiter
package candle_pkg;

  localparam int BRIGHT_WIDTH = 8;

  typedef enum logic [1:0] {
    HOLD      = 2'b00,
    RAMP_UP   = 2'b01,
    RAMP_DOWN = 2'b10
  } ramp_dir_e;

endpackage

// File: rtl/flicker_slew_if.sv
// flicker_slew_if
//   Bundles the signals between the flicker generator / PWM stage and the
//   slew limiter.
//   - enable       : ramp tick strobe
//   - target       : raw brightness target
//   - target_valid : target is valid this cycle
//   - period_start : PWM period boundary strobe
//   - value        : duty value handed to the PWM
//   - settled      : level has reached target and value is up to date
//   - ramp_dir     : HOLD / RAMP_UP / RAMP_DOWN
//   master drives the strobes and target, slave is the slew limiter.
interface flicker_slew_if
  import candle_pkg::*;
#(
  parameter int WIDTH = BRIGHT_WIDTH
);

  logic             enable;
  logic [WIDTH-1:0] target;
  logic             target_valid;
  logic             period_start;
  logic [WIDTH-1:0] value;
  logic             settled;
  logic [1:0]       ramp_dir;

  modport master (
    output enable, target, target_valid, period_start,
    input  value, settled, ramp_dir
  );

  modport slave (
    input  enable, target, target_valid, period_start,
    output value, settled, ramp_dir
  );

endinterface

// File: rtl/flicker_slew_step.sv
// slew_step
//   Purely combinational single ramp step: moves cur toward tgt by at most
//   STEP without overshooting and without wrapping.
//   - cur : current working level
//   - tgt : clamped target level
//   - nxt : level after one step
//   - dir : direction of the step taken (HOLD when cur == tgt)
module slew_step
  import candle_pkg::*;
#(
  parameter int WIDTH = BRIGHT_WIDTH,
  parameter int STEP  = 4
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] tgt,
  output logic [WIDTH-1:0] nxt,
  output ramp_dir_e        dir
);

  localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);

  logic [WIDTH:0] diff;
  logic [WIDTH:0] mag;

  // The step magnitude is min(STEP, |tgt-cur|) in WIDTH+1 bits, so the
  // result can never pass the target and therefore never wraps.
  always_comb begin
    dir  = HOLD;
    nxt  = cur;
    diff = '0;
    mag  = '0;
    if (cur < tgt) begin
      dir  = RAMP_UP;
      diff = {1'b0, tgt} - {1'b0, cur};
      mag  = (diff < STEP_X) ? diff : STEP_X;
      nxt  = WIDTH'({1'b0, cur} + mag);
    end else if (cur > tgt) begin
      dir  = RAMP_DOWN;
      diff = {1'b0, cur} - {1'b0, tgt};
      mag  = (diff < STEP_X) ? diff : STEP_X;
      nxt  = WIDTH'({1'b0, cur} - mag);
    end
  end

endmodule

// File: rtl/flicker_slew.sv
// flicker_slew
//   Slew limiter between the flicker generator and the PWM stage. Ramps a
//   working level toward the latest (floored) target one bounded step per
//   enable tick and hands it to the PWM only on period boundaries.
//   - clk   : system clock
//   - reset : synchronous, active-high reset
//   - bus   : flicker_slew_if slave (enable, target, target_valid,
//             period_start in; value, settled, ramp_dir out)
module flicker_slew
  import candle_pkg::*;
#(
  parameter int WIDTH       = BRIGHT_WIDTH,
  parameter int STEP        = 4,
  parameter int MIN_LEVEL   = 16,
  parameter int RESET_LEVEL = 128
) (
  input  logic           clk,
  input  logic           reset,
  flicker_slew_if.slave  bus
);

  localparam logic [WIDTH-1:0] MIN_L   = WIDTH'(MIN_LEVEL);
  localparam logic [WIDTH-1:0] RESET_L = WIDTH'(RESET_LEVEL);

  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic             settled_q, settled_d;
  ramp_dir_e        state_q, state_d;

  logic [WIDTH-1:0] step_nxt;
  ramp_dir_e        step_dir;

  // Step is always computed from the pre-edge cur_q/tgt_q, so a target
  // written in the same cycle as a tick only affects the following tick.
  slew_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .cur (cur_q),
    .tgt (tgt_q),
    .nxt (step_nxt),
    .dir (step_dir)
  );

  // Next-state logic: target floor, ramp step, period-aligned output load
  // and the direction/settled status derived from the next-state values.
  always_comb begin
    tgt_d     = tgt_q;
    cur_d     = cur_q;
    value_d   = value_q;
    state_d   = HOLD;
    settled_d = 1'b0;

    if (bus.target_valid) begin
      tgt_d = (bus.target < MIN_L) ? MIN_L : bus.target;
    end

    if (bus.enable && (step_dir != HOLD)) begin
      cur_d = step_nxt;
    end

    // Loads the pre-step level; a step in the same cycle shows up at the
    // next period boundary.
    if (bus.period_start) begin
      value_d = cur_q;
    end

    if (cur_d < tgt_d) begin
      state_d = RAMP_UP;
    end else if (cur_d > tgt_d) begin
      state_d = RAMP_DOWN;
    end

    settled_d = (state_d == HOLD) && (value_d == cur_d);
  end

  // State registers; reset discards any pending target and ramp.
  always_ff @(posedge clk) begin
    if (reset) begin
      tgt_q     <= RESET_L;
      cur_q     <= RESET_L;
      value_q   <= RESET_L;
      state_q   <= HOLD;
      settled_q <= 1'b1;
    end else begin
      tgt_q     <= tgt_d;
      cur_q     <= cur_d;
      value_q   <= value_d;
      state_q   <= state_d;
      settled_q <= settled_d;
    end
  end

  assign bus.value    = value_q;
  assign bus.settled  = settled_q;
  assign bus.ramp_dir = state_q;

endmodule

// File: tb/tb_flicker_slew.sv
// tb_flicker_slew
//   Directed testbench for flicker_slew. Stimulus tasks push hand-computed
//   expected outputs into a queue tagged with the cycle they apply to; an
//   independent monitor pops and compares after each rising edge.
module tb_flicker_slew;

  typedef struct {
    int         due;
    logic [7:0] v;
    logic       s;
    logic [1:0] d;
    string      name;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   failures;
  exp_t expq[$];

  flicker_slew_if #(.WIDTH(8)) bus ();

  flicker_slew #(
    .WIDTH       (8),
    .STEP        (4),
    .MIN_LEVEL   (16),
    .RESET_LEVEL (128)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Free-running clock, 10 time units period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to tag expectations.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: after each edge, compare every expectation due by now.
  always @(posedge clk) begin
    #1;
    while (expq.size() > 0 && expq[0].due <= cyc) begin
      exp_t e;
      e = expq.pop_front();
      checks++;
      if (bus.value !== e.v || bus.settled !== e.s || bus.ramp_dir !== e.d) begin
        failures++;
        $display("[TB] FAIL %s: got value=%0d settled=%0b ramp_dir=%b, expected value=%0d settled=%0b ramp_dir=%b",
                 e.name, bus.value, bus.settled, bus.ramp_dir, e.v, e.s, e.d);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one cycle of inputs at the falling edge.
  task automatic applyStimulus(input logic r, input logic en, input logic tv,
                               input logic [7:0] t, input logic ps);
    @(negedge clk);
    reset            = r;
    bus.enable       = en;
    bus.target_valid = tv;
    bus.target       = t;
    bus.period_start = ps;
  endtask

  // Queue the outputs expected right after the edge following the last drive.
  task automatic checkOutput(input string name, input logic [7:0] v,
                             input logic s, input logic [1:0] d);
    exp_t e;
    e.due  = cyc + 1;
    e.v    = v;
    e.s    = s;
    e.d    = d;
    e.name = name;
    expq.push_back(e);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
  endtask

  task automatic tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
  endtask

  task automatic pulse();
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
  endtask

  task automatic setTarget(input logic [7:0] t);
    applyStimulus(1'b0, 1'b0, 1'b1, t, 1'b0);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
  endtask

  initial begin
    cyc              = 0;
    checks           = 0;
    failures         = 0;
    reset            = 1'b1;
    bus.enable       = 1'b0;
    bus.target       = 8'd0;
    bus.target_valid = 1'b0;
    bus.period_start = 1'b0;

    // 1: reset for 2 cycles, then 100 idle cycles
    doReset();
    doReset();
    checkOutput("reset_state", 8'd128, 1'b1, 2'b00);
    idle();
    checkOutput("idle_first", 8'd128, 1'b1, 2'b00);
    for (int i = 0; i < 99; i++) idle();
    checkOutput("idle_100", 8'd128, 1'b1, 2'b00);

    // 2: ramp up to 140 in three ticks
    setTarget(8'd140); checkOutput("up_target", 8'd128, 1'b0, 2'b01);
    tick();            checkOutput("up_tick1", 8'd128, 1'b0, 2'b01);
    pulse();           checkOutput("up_ps1", 8'd132, 1'b0, 2'b01);
    tick();            checkOutput("up_tick2", 8'd132, 1'b0, 2'b01);
    pulse();           checkOutput("up_ps2", 8'd136, 1'b0, 2'b01);
    tick();            checkOutput("up_tick3", 8'd136, 1'b0, 2'b00);
    pulse();           checkOutput("up_ps3", 8'd140, 1'b1, 2'b00);

    // 3: target below floor, ramp down 128 -> 16 in 28 ticks
    doReset();
    setTarget(8'd5);   checkOutput("floor_target", 8'd128, 1'b0, 2'b10);
    for (int i = 0; i < 27; i++) tick();
    checkOutput("floor_tick27", 8'd128, 1'b0, 2'b10);
    tick();            checkOutput("floor_tick28", 8'd128, 1'b0, 2'b00);
    pulse();           checkOutput("floor_ps", 8'd16, 1'b1, 2'b00);
    for (int i = 0; i < 4; i++) tick();
    pulse();           checkOutput("floor_hold", 8'd16, 1'b1, 2'b00);

    // 4: no overshoot, no wrap at top, floor at bottom
    doReset();
    setTarget(8'd130); checkOutput("small_target", 8'd128, 1'b0, 2'b01);
    tick();            checkOutput("small_tick", 8'd128, 1'b0, 2'b00);
    pulse();           checkOutput("small_ps", 8'd130, 1'b1, 2'b00);
    setTarget(8'd252); checkOutput("to252_target", 8'd130, 1'b0, 2'b01);
    for (int i = 0; i < 31; i++) tick();
    checkOutput("to252_done", 8'd130, 1'b0, 2'b00);
    pulse();           checkOutput("to252_ps", 8'd252, 1'b1, 2'b00);
    setTarget(8'd255); checkOutput("to255_target", 8'd252, 1'b0, 2'b01);
    tick();            checkOutput("to255_tick", 8'd252, 1'b0, 2'b00);
    pulse();           checkOutput("to255_ps", 8'd255, 1'b1, 2'b00);
    setTarget(8'd3);   checkOutput("to3_target", 8'd255, 1'b0, 2'b10);
    for (int i = 0; i < 59; i++) tick();
    checkOutput("to3_tick59", 8'd255, 1'b0, 2'b10);
    tick();            checkOutput("to3_tick60", 8'd255, 1'b0, 2'b00);
    pulse();           checkOutput("to3_ps", 8'd16, 1'b1, 2'b00);

    // 5: target and tick together; tick and period_start together
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b1, 8'd200, 1'b0);
    checkOutput("same_cyc_tgt", 8'd128, 1'b0, 2'b01);
    pulse();           checkOutput("same_cyc_ps", 8'd128, 1'b0, 2'b01);
    tick();            checkOutput("same_cyc_tick", 8'd128, 1'b0, 2'b01);
    pulse();           checkOutput("same_cyc_ps2", 8'd132, 1'b0, 2'b01);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 1'b1);
    checkOutput("tick_and_ps", 8'd132, 1'b0, 2'b01);
    pulse();           checkOutput("tick_and_ps_next", 8'd136, 1'b0, 2'b01);

    // 6: reset in the middle of a ramp
    doReset();
    setTarget(8'd240); checkOutput("mid_target", 8'd128, 1'b0, 2'b01);
    for (int i = 0; i < 13; i++) tick();
    pulse();           checkOutput("mid_level180", 8'd180, 1'b0, 2'b01);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'd240, 1'b1);
    checkOutput("mid_reset", 8'd128, 1'b1, 2'b00);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'd0, 1'b1);
    checkOutput("mid_after_reset", 8'd128, 1'b1, 2'b00);

    // Drain the scoreboard.
    idle();
    idle();
    idle();
    if (expq.size() != 0) begin
      failures += expq.size();
      $display("[TB] FAIL drain: got %0d unchecked expectations, expected 0", expq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
